// File: rtl/aftab_shift_register_seq.sv
// rtl/aftab_shift_register_seq.sv - multi-mode shift register with counted multi-step shift sequencer
module aftab_shift_register_seq #(
    parameter int SIZE = 32,
    parameter int SHW  = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] dataIn,
    input  logic            ld,
    input  logic            init,
    input  logic            start,
    input  logic            shEn,
    input  logic [1:0]      mode,
    input  logic [SHW-1:0]  shamt,
    input  logic            serIn,
    output logic [SIZE-1:0] dataOut,
    output logic            serOut,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] data_q;
    logic            ser_q;
    logic [SHW-1:0]  cnt_q;
    logic [1:0]      mode_q;
    logic [1:0]      step_mode;
    logic [SIZE-1:0] step_data;
    logic            step_ser;
    logic            accept;

    assign accept = (state_q != SHIFT);

    // A running operation uses the mode latched at start; single steps use the live mode.
    always_comb begin
        step_mode = (state_q == SHIFT) ? mode_q : mode;
        step_data = data_q;
        step_ser  = ser_q;
        case (step_mode)
            2'b00: begin
                step_data = {data_q[SIZE-2:0], serIn};
                step_ser  = data_q[SIZE-1];
            end
            2'b01: begin
                step_data = {serIn, data_q[SIZE-1:1]};
                step_ser  = data_q[0];
            end
            2'b10: begin
                step_data = {data_q[SIZE-1], data_q[SIZE-1:1]};
                step_ser  = data_q[0];
            end
            default: begin
                step_data = {data_q[SIZE-2:0], data_q[SIZE-1]};
                step_ser  = data_q[SIZE-1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ser_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            if (init) begin
                data_q <= '0;
                ser_q  <= 1'b0;
                cnt_q  <= '0;
            end else if (!accept) begin
                data_q <= step_data;
                ser_q  <= step_ser;
                cnt_q  <= cnt_q - SHW'(1);
            end else if (ld) begin
                data_q <= dataIn;
            end else if (start) begin
                mode_q <= mode;
                cnt_q  <= shamt;
            end else if (shEn) begin
                data_q <= step_data;
                ser_q  <= step_ser;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                SHIFT: state_d = (cnt_q == SHW'(1)) ? DONE : SHIFT;
                default: begin
                    if (ld)
                        state_d = IDLE;
                    else if (start)
                        state_d = (shamt == '0) ? DONE : SHIFT;
                    else
                        state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = data_q;
        serOut  = ser_q;
        busy    = (state_q == SHIFT);
        done    = (state_q == DONE);
    end

endmodule
